// File: rtl/vga_drawing_axi_regs.sv
// AXI4-Lite register bank for the VGA drawing peripheral: four R/W registers,
// and a GO write to CTRL hands a snapshot of POS/SIZE/COLOR to the drawing core.
module vga_drawing_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int COORD_W            = 12
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [COORD_W-1:0]              cmd_x,
  output logic [COORD_W-1:0]              cmd_y,
  output logic [COORD_W-1:0]              cmd_w,
  output logic [COORD_W-1:0]              cmd_h,
  output logic [11:0]                     cmd_rgb
);
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs;
  logic                          live;
  logic                          aw_lat, w_lat;
  logic [1:0]                    aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]                 w_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_val;
  logic                          do_wr, launch;
  logic                          unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // live keeps every READY low while reset is held and for the first cycle after
  assign S_AXI_AWREADY = live && !aw_lat && !S_AXI_BVALID;
  assign S_AXI_WREADY  = live && !w_lat  && !S_AXI_BVALID;
  assign S_AXI_ARREADY = live && !S_AXI_RVALID;
  assign S_AXI_RRESP   = 2'b00;

  assign do_wr  = aw_lat && w_lat && !S_AXI_BVALID;
  assign launch = do_wr && (aw_idx == 2'd0) && w_strb[0] && w_data[0];

  always_comb begin
    wr_val = regs[aw_idx];
    for (int b = 0; b < NB; b++)
      if (w_strb[b]) wr_val[8*b +: 8] = w_data[8*b +: 8];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      regs         <= '0;
      live         <= 1'b0;
      aw_lat       <= 1'b0;
      w_lat        <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= 2'b00;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      cmd_valid    <= 1'b0;
      cmd_x        <= '0;
      cmd_y        <= '0;
      cmd_w        <= '0;
      cmd_h        <= '0;
      cmd_rgb      <= '0;
    end else begin
      live <= 1'b1;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_lat <= 1'b1;
        aw_idx <= S_AXI_AWADDR[3:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_lat  <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      // latches are released at the write itself; BVALID then blocks new beats
      if (do_wr) begin
        regs[aw_idx] <= wr_val;
        aw_lat       <= 1'b0;
        w_lat        <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (launch && cmd_valid) ? 2'b10 : 2'b00;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      // a launch only writes CTRL, so POS/SIZE/COLOR already hold post-write values
      if (launch && !cmd_valid) begin
        cmd_valid <= 1'b1;
        cmd_x     <= regs[1][COORD_W-1:0];
        cmd_y     <= regs[1][16 +: COORD_W];
        cmd_w     <= regs[2][COORD_W-1:0];
        cmd_h     <= regs[2][16 +: COORD_W];
        cmd_rgb   <= regs[3][11:0];
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_RDATA  <= regs[S_AXI_ARADDR[3:2]];
        S_AXI_RVALID <= 1'b1;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vga_drawing_axi_regs.sv
// Scoreboard bench for vga_drawing_axi_regs: stimulus pushes expected B/R/cmd
// responses, a negedge monitor pops and compares them at each handshake.
module tb_vga_drawing_axi_regs;
  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic [3:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
  logic        S_AXI_ARVALID = 0, S_AXI_RREADY = 0, cmd_ready = 0;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;
  logic        cmd_valid;
  logic [11:0] cmd_x, cmd_y, cmd_w, cmd_h, cmd_rgb;

  vga_drawing_axi_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_rgb(cmd_rgb)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed { logic [11:0] x, y, w, h, rgb; } cmd_t;

  int total = 0, bad = 0;
  logic [31:0] mem [4];
  bit          pending;
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  cmd_t        cq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  // monitor: every handshake must match the oldest expected entry
  always @(negedge ACLK) begin
    if (S_AXI_BVALID && S_AXI_BREADY) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", S_AXI_BRESP, bq.pop_front());
    end
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        chk("rdata", S_AXI_RDATA, rq.pop_front());
        chk("rresp", S_AXI_RRESP, 2'b00);
      end
    end
    if (cmd_valid && cmd_ready) begin
      if (cq.size() == 0) chk("cmd_unexpected", 1, 0);
      else chk("cmd", {cmd_x, cmd_y, cmd_w, cmd_h, cmd_rgb}, cq.pop_front());
    end
  end

  task automatic send_aw(input logic [3:0] a, input int dly);
    int n;
    repeat (dly) tick();
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (S_AXI_AWREADY) break; end
    if (n == 50) chk("aw_timeout", 1, 0);
    tick(); S_AXI_AWVALID = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    repeat (dly) tick();
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (S_AXI_WREADY) break; end
    if (n == 50) chk("w_timeout", 1, 0);
    tick(); S_AXI_WVALID = 0;
  endtask

  // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int skew, input int bdly);
    int n;
    int i = int'(a[3:2]);
    for (int b = 0; b < 4; b++) if (s[b]) mem[i][8*b +: 8] = d[8*b +: 8];
    if (i == 0 && s[0] && d[0]) begin
      if (!pending) begin
        cq.push_back({mem[1][11:0], mem[1][27:16], mem[2][11:0], mem[2][27:16], mem[3][11:0]});
        pending = 1;
        bq.push_back(2'b00);
      end else bq.push_back(2'b10);
    end else bq.push_back(2'b00);
    fork
      send_aw(a, skew > 0 ? skew : 0);
      send_w(d, s, skew < 0 ? -skew : 0);
    join
    for (n = 0; n < 50; n++) begin
      if (S_AXI_BVALID) break;
      tick();
    end
    if (n == 50) chk("b_timeout", 1, 0);
    repeat (bdly) tick();
    chk("bvalid_held", S_AXI_BVALID, 1);
    S_AXI_BREADY = 1;
    tick(); S_AXI_BREADY = 0;
    chk("bvalid_clr", S_AXI_BVALID, 0);
    chk("cmd_valid", cmd_valid, pending);
  endtask

  task automatic rd(input logic [3:0] a, input int rdly);
    int n;
    rq.push_back(mem[a[3:2]]);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (S_AXI_ARREADY) break; end
    if (n == 50) chk("ar_timeout", 1, 0);
    tick(); S_AXI_ARVALID = 0;
    for (n = 0; n < 50; n++) begin
      if (S_AXI_RVALID) break;
      tick();
    end
    if (n == 50) chk("r_timeout", 1, 0);
    repeat (rdly) tick();
    S_AXI_RREADY = 1;
    tick(); S_AXI_RREADY = 0;
  endtask

  task automatic accept();
    if (pending) begin
      cmd_ready = 1;
      tick(); cmd_ready = 0;
      pending = 0;
      chk("cmd_clr", cmd_valid, 0);
    end
  endtask

  task automatic do_reset();
    ARESETN = 0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    pending = 0;
    bq.delete(); rq.delete(); cq.delete();
    repeat (2) tick();
    ARESETN = 1;
    repeat (2) tick();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    pending = 0;
    repeat (2) tick();
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready",  S_AXI_WREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_bvalid",  S_AXI_BVALID, 0);
    chk("rst_rvalid",  S_AXI_RVALID, 0);
    chk("rst_bresp",   S_AXI_BRESP, 0);
    chk("rst_rdata",   S_AXI_RDATA, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd", {cmd_x, cmd_y, cmd_w, cmd_h, cmd_rgb}, 0);
    ARESETN = 1;
    repeat (2) tick();

    // sequential registers, then a launch picking up x=2 w=3 rgb=4
    wr(4'h4, 32'h2, 4'hF, 0, 0);
    wr(4'h8, 32'h3, 4'hF, 0, 0);
    wr(4'hC, 32'h4, 4'hF, 0, 0);
    wr(4'h0, 32'h1, 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) rd(4'(i * 4), 0);
    accept();

    // launch snapshot, later POS write must not leak into cmd_*
    wr(4'h4, 32'h0064_0032, 4'hF, 0, 0);
    wr(4'h8, 32'h0010_0020, 4'hF, 0, 0);
    wr(4'hC, 32'h0000_0F00, 4'hF, 0, 1);
    wr(4'h0, 32'h1, 4'hF, 0, 0);
    chk("snap_x", cmd_x, 12'h032);
    chk("snap_rgb", cmd_rgb, 12'hF00);
    wr(4'h4, 32'h0, 4'hF, 0, 0);
    chk("snap_x_stable", cmd_x, 12'h032);
    wr(4'h0, 32'h1, 4'hF, 1, 0);
    chk("drop_y", cmd_y, 12'h064);
    accept();

    // byte strobes after reset, with unaligned address
    do_reset();
    wr(4'hE, 32'hAABB_CCDD, 4'b0101, 0, 0);
    rd(4'hD, 1);

    // channel skew in both directions, BREADY held back
    wr(4'h4, 32'h1234_5678, 4'hF, 3, 2);
    rd(4'h4, 0);
    wr(4'h8, 32'h9ABC_DEF0, 4'hF, -3, 2);
    rd(4'h8, 2);

    repeat (150) begin
      case ($urandom_range(0, 3))
        0, 1: wr(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
        2:    rd(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        default: if ($urandom_range(0, 1) == 1) accept();
      endcase
    end
    accept();

    // reset while a command is pending and read data is waiting
    wr(4'h0, 32'h1, 4'h1, 0, 0);
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (S_AXI_ARREADY) break; end
    if (n == 50) chk("ar_timeout", 1, 0);
    tick(); S_AXI_ARVALID = 0;
    tick();
    chk("pre_rst_rvalid", S_AXI_RVALID, 1);
    chk("pre_rst_cmd_valid", cmd_valid, 1);
    #2 ARESETN = 0;
    #1;
    chk("async_rvalid", S_AXI_RVALID, 0);
    chk("async_cmd_valid", cmd_valid, 0);
    do_reset();
    for (int i = 0; i < 4; i++) rd(4'(i * 4), 0);

    repeat (3) tick();
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("cq_empty", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
